// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared encodings for the multicycle RV32 control path
//               (FSM states, ALUOp, alu_control, imm_src, opcodes, mux codes).
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    localparam logic [1:0] c_IMM_I = 2'b00;
    localparam logic [1:0] c_IMM_S = 2'b01;
    localparam logic [1:0] c_IMM_B = 2'b10;
    localparam logic [1:0] c_IMM_J = 2'b11;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        logic [1:0] sel;
        sel = c_IMM_I;
        case (op)
            c_OP_STORE:  sel = c_IMM_S;
            c_OP_BRANCH: sel = c_IMM_B;
            c_OP_JAL:    sel = c_IMM_J;
            default:     sel = c_IMM_I;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps ALUOp plus instruction function fields to alu_control.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = c_ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alu_control = c_ALU_ADD;
            ALUOP_SUB: o_alu_control = c_ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op5=1) with funct7b5 subtracts; addi never does
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  o_alu_control = c_ALU_SLT;
                    3'b110:  o_alu_control = c_ALU_OR;
                    3'b111:  o_alu_control = c_ALU_AND;
                    default: o_alu_control = c_ALU_ADD;
                endcase
            end
            default: o_alu_control = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle RV32 core; sequences each
//               instruction and drives datapath enables, muxes and ALU select.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t r_state;
    state_t w_cur;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pc_write;
    logic   w_mem_write;
    logic   w_ir_write;
    logic   w_reg_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // While reset is asserted the decode shows FETCH regardless of the register
    assign w_cur = reset ? S_FETCH : r_state;

    always_comb begin
        w_next      = S_FETCH;
        w_aluop     = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = c_RES_ALUOUT;
        alu_src_a   = c_SRCA_PC;
        alu_src_b   = c_SRCB_RS2;
        illegal     = 1'b0;
        case (w_cur)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = c_SRCB_FOUR;
                result_src = c_RES_ALURESULT;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = c_SRCA_OLDPC;
                alu_src_b = c_SRCB_IMM;
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_R:                w_next = S_EXECUTER;
                    c_OP_IMM:              w_next = S_EXECUTEI;
                    c_OP_BRANCH:           w_next = S_BEQ;
                    c_OP_JAL:              w_next = S_JAL;
                    default:               w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = c_SRCA_RS1;
                alu_src_b = c_SRCB_IMM;
                w_next    = (opcode == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = c_RES_MEMDATA;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = c_SRCA_RS1;
                alu_src_b = c_SRCB_RS2;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = c_SRCA_RS1;
                alu_src_b = c_SRCB_IMM;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src  = c_RES_ALUOUT;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = c_SRCA_RS1;
                alu_src_b  = c_SRCB_RS2;
                w_aluop    = ALUOP_SUB;
                w_pc_write = zero;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = c_SRCA_OLDPC;
                alu_src_b  = c_SRCB_FOUR;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                w_next  = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign pc_write  = w_pc_write  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign imm_src   = imm_src_for(opcode);
    assign state_dbg = w_cur;

    alu_decoder u_alu_decoder (
        .i_aluop       (w_aluop),
        .i_funct3      (funct3),
        .i_op5         (opcode[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (alu_control)
    );

endmodule
`default_nettype wire
